serial_add_ctrl: RTL

Bit-serial adder controller that sequences a single one-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands. It owns the operand and sum shift registers, the carry flip-flop, the bit counter and the valid/ready handshakes. It sits between an operand producer and a result consumer, and replaces a WIDTH-bit ripple adder where area matters more than latency.

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_add_ctrl_fa_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit combinational full adder; the only adder logic in the controller.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced over WIDTH cycles.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic             fa_s;
    logic             fa_co;
`ifdef SERIAL_ADD_OVF_EN
    logic             msb_carry;
`endif

    fa_cell u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
`ifdef SERIAL_ADD_OVF_EN
    // Both terms are frozen at the last RUN edge, so ovf is stable through DONE.
    assign ovf = msb_carry ^ cout;
`endif

    // Controller FSM with datapath shift registers and result holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= {CW{1'b0}};
            a_sh      <= {WIDTH{1'b0}};
            b_sh      <= {WIDTH{1'b0}};
            sum_sh    <= {WIDTH{1'b0}};
            carry     <= 1'b0;
            sum       <= {WIDTH{1'b0}};
            cout      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            msb_carry <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        cnt    <= {CW{1'b0}};
                        sum_sh <= {WIDTH{1'b0}};
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    carry  <= fa_co;
                    if (cnt == LAST) begin
                        // Result registers change only here, keeping sum/cout quiet during RUN.
                        sum       <= {fa_s, sum_sh[WIDTH-1:1]};
                        cout      <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        msb_carry <= carry;
`endif
                        state     <= DONE;
                    end else begin
                        cnt       <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end else begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
